aes_ctr_keystream_buffer: RTL and testbench

- Downstream consumer of the 4-block AES-256-CTR batch engine.
- Accepts 512-bit keystream batches (4 × 128-bit blocks) on the engine's finished strobe.
- Buffers them in a 2-entry ping-pong store and serialises them as 64-bit words over a valid/ready stream to the XOF/PRF sampler.
- Counts blocks per session and stops at the mode-specific target (XOF 44 blocks, PRF 8 blocks).

---
 rtl/aes_ctr_keystream_buffer.sv | 144 ++++++++++++++
 tb/tb_aes_ctr_keystream_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_keystream_buffer.sv
// AES-CTR keystream buffer: 2-slot ping-pong batch store,
// serialised as 64-bit words with per-session block targets.
module aes_ctr_keystream_buffer #(
    parameter int BATCH_BITS        = 512,
    parameter int BLOCK_BITS        = 128,
    parameter int OUT_BITS          = 64,
    parameter int XOF_TARGET_BLOCKS = 44,
    parameter int PRF_TARGET_BLOCKS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [BATCH_BITS-1:0] batch_in,
    input  logic                  batch_valid,
    output logic                  batch_req,
    output logic [OUT_BITS-1:0]   ks_data,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic                  ks_last,
    output logic                  done,
    output logic                  busy,
    output logic                  overflow_err
);

    localparam int WPBLK = BLOCK_BITS / OUT_BITS;
    localparam int WPBAT = BATCH_BITS / OUT_BITS;
    localparam int BLKPB = BATCH_BITS / BLOCK_BITS;
    localparam int WW    = $clog2(WPBAT);

    localparam logic [15:0] XOF_WORDS = 16'(XOF_TARGET_BLOCKS * WPBLK);
    localparam logic [15:0] PRF_WORDS = 16'(PRF_TARGET_BLOCKS * WPBLK);
    localparam logic [7:0]  XOF_BATCHES =
        8'((XOF_TARGET_BLOCKS + BLKPB - 1) / BLKPB);
    localparam logic [7:0]  PRF_BATCHES =
        8'((PRF_TARGET_BLOCKS + BLKPB - 1) / BLKPB);
    localparam logic [WW-1:0] W_LAST = WW'(WPBAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FIN    = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  mode_q;
    logic [BATCH_BITS-1:0] slot_data [2];
    logic [1:0]            slot_full;
    logic                  head;
    logic                  tail;
    logic [WW-1:0]         w;
    logic [15:0]           word_cnt;
    logic [7:0]            batch_cnt;
    logic [15:0]           words_total;
    logic [7:0]            batches_needed;
    logic                  start_ok;
    logic                  accept;
    logic                  xfer;
    logic                  final_word;
    logic                  free_head;
    logic [BATCH_BITS-1:0] head_shift;

    assign words_total    = mode_q ? PRF_WORDS : XOF_WORDS;
    assign batches_needed = mode_q ? PRF_BATCHES : XOF_BATCHES;
    assign start_ok       = (state == IDLE) && start;

    assign batch_req = (state == ACTIVE)
                     && !(slot_full[0] && slot_full[1])
                     && (batch_cnt < batches_needed);
    assign accept    = batch_valid && batch_req;

    assign ks_valid   = slot_full[head];
    assign xfer       = ks_valid && ks_ready;
    assign final_word = (word_cnt == words_total - 16'd1);
    assign ks_last    = ks_valid && final_word;
    // the slot frees after its 8th word, or early on the session's last
    // word so a truncated final batch never shows its surplus words
    assign free_head  = xfer && ((w == W_LAST) || final_word);

    assign head_shift = slot_data[head] << (int'(w) * OUT_BITS);
    assign ks_data    = ks_valid ? head_shift[BATCH_BITS-1 -: OUT_BITS]
                                 : '0;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ACTIVE;
            ACTIVE:  if (xfer && final_word) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        busy = (state == ACTIVE);
        done = (state == FIN);
    end

    // slot bookkeeping, counters and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            slot_full    <= '0;
            head         <= 1'b0;
            tail         <= 1'b0;
            w            <= '0;
            word_cnt     <= '0;
            batch_cnt    <= '0;
            overflow_err <= 1'b0;
            mode_q       <= rst ? 1'b0 : mode;
        end else begin
            if (batch_valid && !batch_req) overflow_err <= 1'b1;
            if (accept) begin
                slot_full[tail] <= 1'b1;
                tail            <= ~tail;
                batch_cnt       <= batch_cnt + 8'd1;
            end
            if (xfer) begin
                word_cnt <= word_cnt + 16'd1;
                if (free_head) begin
                    slot_full[head] <= 1'b0;
                    head            <= ~head;
                    w               <= '0;
                end else begin
                    w <= w + WW'(1);
                end
            end
        end
    end

    // batch payload storage; contents only matter while the slot is full
    always_ff @(posedge clk) begin
        if (accept) slot_data[tail] <= batch_in;
    end

endmodule

// File: tb/tb_aes_ctr_keystream_buffer.sv
// Directed bench for aes_ctr_keystream_buffer: PRF/XOF sessions,
// stalls, overflow, ignored start, reset, truncated PRF build.
module tb_aes_ctr_keystream_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [511:0] batch_in;
    logic         batch_valid;
    logic         ks_ready;
    logic         sel6;

    logic        req0, val0, last0, done0, busy0, ovf0;
    logic [63:0] dat0;
    logic        req6, val6, last6, done6, busy6, ovf6;
    logic [63:0] dat6;

    logic        o_req, o_valid, o_last, o_done, o_busy, o_ovf;
    logic [63:0] o_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_ctr_keystream_buffer dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .batch_in(batch_in), .batch_valid(batch_valid),
        .batch_req(req0), .ks_data(dat0), .ks_valid(val0),
        .ks_ready(ks_ready), .ks_last(last0), .done(done0),
        .busy(busy0), .overflow_err(ovf0)
    );

    aes_ctr_keystream_buffer #(.PRF_TARGET_BLOCKS(6)) dut6 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .batch_in(batch_in), .batch_valid(batch_valid),
        .batch_req(req6), .ks_data(dat6), .ks_valid(val6),
        .ks_ready(ks_ready), .ks_last(last6), .done(done6),
        .busy(busy6), .overflow_err(ovf6)
    );

    assign o_req   = sel6 ? req6  : req0;
    assign o_valid = sel6 ? val6  : val0;
    assign o_last  = sel6 ? last6 : last0;
    assign o_done  = sel6 ? done6 : done0;
    assign o_busy  = sel6 ? busy6 : busy0;
    assign o_ovf   = sel6 ? ovf6  : ovf0;
    assign o_data  = sel6 ? dat6  : dat0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wordv(input int k, input int i);
        return {8'(k), 8'(i), 16'hBEEF, 8'(k) ^ 8'hFF, 8'(i) ^ 8'h3C,
                16'h5A5A};
    endfunction

    function automatic logic [511:0] mkbatch(input int k);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[511-64*i -: 64] = wordv(k, i);
        return b;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
        check({tag, "_req"},   {63'd0, o_req},   64'd0);
        check({tag, "_busy"},  {63'd0, o_busy},  64'd0);
        check({tag, "_done"},  {63'd0, o_done},  64'd0);
        check({tag, "_last"},  {63'd0, o_last},  64'd0);
        check({tag, "_ovf"},   {63'd0, o_ovf},   64'd0);
        check({tag, "_data"},  o_data,           64'd0);
    endtask

    // engine replies 3 cycles after seeing batch_req; sink drives ks_ready
    task automatic run_session(input logic m, input int nwords,
                               input int nbatches, input bit rnd,
                               input int mid, input bit do_start,
                               input int acc0, input logic exp_ovf);
        int   n        = 0;
        int   acc      = acc0;
        int   dly      = 0;
        int   cyc      = 0;
        int   dones    = 0;
        bit   pend     = 0;
        bit   stall    = 0;
        bit   fin      = 0;
        bit   exp_done = 0;
        bit   req_late = 0;
        bit   mid_done = 0;
        logic [63:0] pdata = '0;
        if (do_start) begin
            mode  = m;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_clears_ovf", {63'd0, o_ovf}, 64'd0);
        end
        while (!fin && cyc < 4000) begin
            batch_valid = 1'b0;
            start       = 1'b0;
            mode        = m;
            check("done", {63'd0, o_done}, {63'd0, exp_done});
            if (o_done) begin
                dones++;
                fin = 1;
                check("busy_at_done", {63'd0, o_busy}, 64'd0);
                check("nwords", 64'(n), 64'(nwords));
            end else begin
                check("busy", {63'd0, o_busy}, 64'd1);
                if (stall) begin
                    check("stall_valid", {63'd0, o_valid}, 64'd1);
                    check("stall_data", o_data, pdata);
                end
                if (acc >= nbatches && o_req) req_late = 1;
                if (!pend && o_req && acc < nbatches) begin
                    pend = 1;
                    dly  = 3;
                end else if (pend) begin
                    dly--;
                    if (dly == 0) begin
                        check("req_at_pulse", {63'd0, o_req}, 64'd1);
                        batch_in    = mkbatch(acc);
                        batch_valid = 1'b1;
                        acc++;
                        pend = 0;
                    end
                end
                if (n == mid && !mid_done) begin
                    start    = 1'b1;
                    mode     = ~m;
                    mid_done = 1;
                end
                ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (o_valid) begin
                    check("last", {63'd0, o_last},
                          {63'd0, (n == nwords - 1)});
                end
                if (o_valid && ks_ready) begin
                    check("word", o_data, wordv(n / 8, n % 8));
                    if (n == nwords - 1) exp_done = 1;
                    n++;
                end
                stall = o_valid && !ks_ready;
                pdata = o_data;
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) check("timeout", 64'd0, 64'd1);
        check("dones", 64'(dones), 64'd1);
        check("batches", 64'(acc), 64'(nbatches));
        check("req_rerise", {63'd0, req_late}, 64'd0);
        check("ovf_end", {63'd0, o_ovf}, {63'd0, exp_ovf});
        ks_ready = 1'b1;
        @(negedge clk);
        check("done_once", {63'd0, o_done}, 64'd0);
        check("idle_busy", {63'd0, o_busy}, 64'd0);
        check("slot_freed", {63'd0, o_valid}, 64'd0);
    endtask

    task automatic wait_req(input string tag);
        int c = 0;
        while (!o_req && c < 50) begin
            @(negedge clk);
            c++;
        end
        check(tag, {63'd0, o_req}, 64'd1);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        mode        = 1'b0;
        batch_in    = '0;
        batch_valid = 1'b0;
        ks_ready    = 1'b0;
        sel6        = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // PRF, always-ready sink
        run_session(1'b1, 16, 2, 1'b0, -1, 1'b1, 0, 1'b0);

        // XOF, random backpressure
        run_session(1'b0, 88, 11, 1'b1, -1, 1'b1, 0, 1'b0);

        // XOF with an ignored start (and flipped mode) at word 30
        run_session(1'b0, 88, 11, 1'b0, 30, 1'b1, 0, 1'b0);

        // overflow: fill both slots with the sink stalled
        ks_ready = 1'b0;
        mode     = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wait_req("ovf_req_fill");
            batch_in    = mkbatch(b);
            batch_valid = 1'b1;
            @(negedge clk);
            batch_valid = 1'b0;
        end
        check("ovf_req_full", {63'd0, o_req}, 64'd0);
        check("ovf_pre", {63'd0, o_ovf}, 64'd0);
        batch_in    = mkbatch(99);
        batch_valid = 1'b1;
        @(negedge clk);
        batch_valid = 1'b0;
        check("ovf_set", {63'd0, o_ovf}, 64'd1);
        repeat (5) @(negedge clk);
        check("ovf_sticky", {63'd0, o_ovf}, 64'd1);
        check("ovf_head_data", o_data, wordv(0, 0));
        run_session(1'b1, 16, 2, 1'b0, -1, 1'b0, 2, 1'b1);

        // reset mid-batch, then a clean PRF session (start clears ovf)
        ks_ready = 1'b1;
        mode     = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_req("rst_req");
        batch_in    = mkbatch(5);
        batch_valid = 1'b1;
        @(negedge clk);
        batch_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_valid", {63'd0, o_valid}, 64'd1);
        check("rst_pre_data", o_data, wordv(5, 1));
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        run_session(1'b1, 16, 2, 1'b0, -1, 1'b1, 0, 1'b0);

        // truncated PRF build: 6 blocks, 12 words
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        sel6 = 1'b1;
        @(negedge clk);
        check_all_zero("prf6_idle");
        run_session(1'b1, 12, 2, 1'b0, -1, 1'b1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
